// File: rtl/usbuart_txmit.sv
// UART transmitter with holding (THR) and shift (TSR) registers and its own 16x baud prescaler.
// Latency: a write accepted at edge n loads the TSR and drives the start bit at edge n+1 when idle.
// Backpressure: tbuf=1 while the THR is full; rising wrn edges seen then are dropped.
module usbuart_txmit #(
   parameter int DIV16    = 652,
   parameter int PARITY   = 0,
   parameter int STOPBITS = 1
) (
   input  logic       CLK,
   input  logic       BTND,
   input  logic [7:0] tdin,
   input  logic       wrn,
   output logic       tbuf,
   output logic       tsre,
   output logic       txd
);

   localparam int             PW        = (DIV16 > 1) ? $clog2(DIV16) : 1;
   localparam logic [PW-1:0]  PMAX      = PW'(DIV16 - 1);
   localparam logic           LAST_STOP = (STOPBITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_tick16;
   logic [2:0]    r_bitcnt;
   logic [2:0]    w_bitcnt_nxt;
   logic          r_stopcnt;
   logic          w_stopcnt_nxt;
   logic          r_wrn_prev;
   logic          r_tbuf;
   logic [7:0]    r_thr;
   logic [7:0]    r_tsr;
   logic          r_txd;
   logic          w_txd_nxt;
   logic          w_load;
   logic          w_wr_acc;
   logic          w_tick;
   logic          w_bit_end;
   logic          w_parity;

   // A write is a fresh 0->1 on wrn while the holding register is empty.
   assign w_wr_acc  = wrn & ~r_wrn_prev & ~r_tbuf;
   assign w_tick    = (r_presc == PMAX);
   assign w_bit_end = w_tick && (r_tick16 == 4'd15);
   assign w_parity  = (PARITY == 1) ? (^r_tsr) : (~^r_tsr);

   assign tbuf = r_tbuf;
   assign tsre = (r_state == ST_IDLE);
   assign txd  = r_txd;

   // Next-state, bit/stop counter and line-level decode; txd follows the state being entered.
   always_comb begin
      w_state_nxt   = r_state;
      w_bitcnt_nxt  = r_bitcnt;
      w_stopcnt_nxt = r_stopcnt;
      w_load        = 1'b0;
      w_txd_nxt     = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (r_tbuf) begin
               w_load      = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) w_state_nxt = (PARITY != 0) ? ST_PAR : ST_STOP;
            end
         end
         ST_PAR: begin
            if (w_bit_end) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (r_stopcnt == LAST_STOP) begin
                  w_stopcnt_nxt = 1'b0;
                  // A queued byte starts immediately, with no idle gap after the stop bit.
                  if (r_tbuf) begin
                     w_load      = 1'b1;
                     w_state_nxt = ST_START;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_stopcnt_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      case (w_state_nxt)
         ST_START: w_txd_nxt = 1'b0;
         ST_DATA:  w_txd_nxt = r_tsr[w_bitcnt_nxt];
         ST_PAR:   w_txd_nxt = w_parity;
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   // State, counters and registered line output.
   always_ff @(posedge CLK) begin
      if (BTND) begin
         r_state   <= ST_IDLE;
         r_bitcnt  <= 3'd0;
         r_stopcnt <= 1'b0;
         r_txd     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_stopcnt <= w_stopcnt_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   // 16x prescaler and tick-in-bit counter; both restart on every TSR load and rest in IDLE.
   always_ff @(posedge CLK) begin
      if (BTND) begin
         r_presc  <= '0;
         r_tick16 <= 4'd0;
      end else if (w_load || (r_state == ST_IDLE)) begin
         r_presc  <= '0;
         r_tick16 <= 4'd0;
      end else if (w_tick) begin
         r_presc  <= '0;
         r_tick16 <= r_tick16 + 4'd1;
      end else begin
         r_presc  <= r_presc + 1'b1;
      end
   end

   // wrn edge detect, holding register fill and hand-off into the shift register.
   always_ff @(posedge CLK) begin
      if (BTND) begin
         r_wrn_prev <= 1'b0;
         r_tbuf     <= 1'b0;
         r_thr      <= 8'd0;
         r_tsr      <= 8'd0;
      end else begin
         r_wrn_prev <= wrn;
         if (w_wr_acc) r_thr <= tdin;
         if (w_load) begin
            r_tsr  <= r_thr;
            r_tbuf <= 1'b0;
         end else if (w_wr_acc) begin
            r_tbuf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_usbuart_txmit.sv
// Bench for usbuart_txmit: four instances (no parity, even, odd, two stop bits) at DIV16=4.
// Frame monitors decode each txd line and compare against a queue of expected bytes.
// Direct checks cover write latency, frame length, back-to-back frames, drops and reset.
module tb_usbuart_txmit;

   logic       CLK = 1'b0;
   logic       BTND = 1'b1;
   logic [7:0] tdin0 = 8'd0;
   logic       wrn0 = 1'b0;
   logic [7:0] tdin1 = 8'd0;
   logic       wrn1 = 1'b0;
   logic [3:0] tbuf_w;
   logic [3:0] tsre_w;
   logic [3:0] txd_w;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] exp_q[4][$];
   int         st_q[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   usbuart_txmit #(.DIV16(4), .PARITY(0), .STOPBITS(1)) u_dut0 (
      .CLK(CLK), .BTND(BTND), .tdin(tdin0), .wrn(wrn0),
      .tbuf(tbuf_w[0]), .tsre(tsre_w[0]), .txd(txd_w[0]));
   usbuart_txmit #(.DIV16(4), .PARITY(1), .STOPBITS(1)) u_dut1 (
      .CLK(CLK), .BTND(BTND), .tdin(tdin1), .wrn(wrn1),
      .tbuf(tbuf_w[1]), .tsre(tsre_w[1]), .txd(txd_w[1]));
   usbuart_txmit #(.DIV16(4), .PARITY(2), .STOPBITS(1)) u_dut2 (
      .CLK(CLK), .BTND(BTND), .tdin(tdin1), .wrn(wrn1),
      .tbuf(tbuf_w[2]), .tsre(tsre_w[2]), .txd(txd_w[2]));
   usbuart_txmit #(.DIV16(4), .PARITY(0), .STOPBITS(2)) u_dut3 (
      .CLK(CLK), .BTND(BTND), .tdin(tdin1), .wrn(wrn1),
      .tbuf(tbuf_w[3]), .tsre(tsre_w[3]), .txd(txd_w[3]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_neg(input int n, output logic ab);
      ab = 1'b0;
      repeat (n) begin
         @(negedge CLK);
         if (BTND) ab = 1'b1;
      end
   endtask

   // Decodes frames on one txd line, sampling each bit mid-way; a reset aborts the frame.
   task automatic monitor(input int id, input int npar, input int nstop);
      logic       prev;
      logic       ab;
      logic [7:0] b;
      logic [7:0] e;
      logic       p;
      prev = 1'b1;
      b    = 8'd0;
      p    = 1'b0;
      forever begin
         @(negedge CLK);
         if (!BTND && prev && (txd_w[id] == 1'b0)) begin
            if (id == 0) st_q.push_back(cyc);
            wait_neg(32, ab);
            if (!ab) check_eq($sformatf("d%0d start bit", id), 32'(txd_w[id]), 32'd0);
            for (int k = 0; k < 8; k++) begin
               if (!ab) begin
                  wait_neg(64, ab);
                  b[k] = txd_w[id];
               end
            end
            if (!ab && npar != 0) begin
               wait_neg(64, ab);
               p = txd_w[id];
            end
            for (int s = 0; s < nstop; s++) begin
               if (!ab) begin
                  wait_neg(64, ab);
                  if (!ab) check_eq($sformatf("d%0d stop bit %0d", id, s), 32'(txd_w[id]), 32'd1);
               end
            end
            if (!ab) begin
               check_eq($sformatf("d%0d frame expected", id), 32'(exp_q[id].size() > 0), 32'd1);
               if (exp_q[id].size() > 0) begin
                  e = exp_q[id].pop_front();
                  check_eq($sformatf("d%0d data", id), 32'(b), 32'(e));
                  if (npar != 0)
                     check_eq($sformatf("d%0d parity", id), 32'(p),
                              32'((npar == 1) ? (^e) : (~^e)));
               end
            end
         end
         prev = BTND ? 1'b1 : txd_w[id];
      end
   endtask

   initial monitor(0, 0, 1);
   initial monitor(1, 1, 1);
   initial monitor(2, 2, 1);
   initial monitor(3, 0, 2);

   // One-cycle wrn pulse on instance 0; the byte is accepted at the posedge inside the pulse.
   task automatic write0(input logic [7:0] d);
      @(negedge CLK);
      tdin0 = d;
      wrn0  = 1'b1;
      @(negedge CLK);
      wrn0  = 1'b0;
      tdin0 = 8'($urandom);
   endtask

   task automatic wait_tsre0(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge CLK);
         #1;
         if (tsre_w[0]) seen = 1'b1;
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int   viol;
      int   cnt;
      int   len[4];
      logic seen;

      // 1: reset and idle
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      BTND = 1'b0;
      check_eq("rst txd", 32'(txd_w), 32'hF);
      check_eq("rst tbuf", 32'(tbuf_w), 32'h0);
      check_eq("rst tsre", 32'(tsre_w), 32'hF);
      viol = 0;
      repeat (100) begin
         @(negedge CLK);
         if (txd_w !== 4'hF || tbuf_w !== 4'h0 || tsre_w !== 4'hF) viol++;
      end
      check_eq("idle violations", 32'(viol), 32'd0);

      // 2: single frame 0x55, latency and length
      exp_q[0].push_back(8'h55);
      @(negedge CLK);
      tdin0 = 8'h55;
      wrn0  = 1'b1;
      @(posedge CLK);
      #1;
      check_eq("t2 tbuf after accept", 32'(tbuf_w[0]), 32'd1);
      check_eq("t2 txd after accept", 32'(txd_w[0]), 32'd1);
      check_eq("t2 tsre after accept", 32'(tsre_w[0]), 32'd1);
      @(posedge CLK);
      #1;
      check_eq("t2 txd start", 32'(txd_w[0]), 32'd0);
      check_eq("t2 tbuf after load", 32'(tbuf_w[0]), 32'd0);
      check_eq("t2 tsre after load", 32'(tsre_w[0]), 32'd0);
      tdin0 = 8'hFF;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 2000) begin
         @(posedge CLK);
         #1;
         cnt++;
         if (tsre_w[0]) seen = 1'b1;
      end
      check_eq("t2 frame length", 32'(cnt), 32'd640);
      @(negedge CLK);
      wrn0 = 1'b0;
      repeat (20) @(negedge CLK);

      // 3: second byte queued mid-frame goes out back-to-back
      st_q.delete();
      exp_q[0].push_back(8'hA5);
      exp_q[0].push_back(8'h3C);
      write0(8'hA5);
      repeat (100) @(negedge CLK);
      write0(8'h3C);
      check_eq("t3 tbuf queued", 32'(tbuf_w[0]), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(posedge CLK);
         #1;
         if (!tbuf_w[0]) seen = 1'b1;
      end
      check_eq("t3 second load seen", 32'(seen), 32'd1);
      check_eq("t3 txd at second load", 32'(txd_w[0]), 32'd0);
      check_eq("t3 tsre at second load", 32'(tsre_w[0]), 32'd0);
      wait_tsre0("t3 idle after frames", 1000);
      check_eq("t3 start count", 32'(st_q.size()), 32'd2);
      if (st_q.size() == 2)
         check_eq("t3 start spacing", 32'(st_q[1] - st_q[0]), 32'd640);
      repeat (20) @(negedge CLK);

      // 4: third write while THR full is dropped
      exp_q[0].push_back(8'h11);
      exp_q[0].push_back(8'h22);
      write0(8'h11);
      write0(8'h22);
      check_eq("t4 tbuf full", 32'(tbuf_w[0]), 32'd1);
      write0(8'h33);
      wait_tsre0("t4 idle after frames", 3000);
      repeat (20) @(negedge CLK);

      // 5: parity and two-stop-bit instances
      for (int k = 1; k < 4; k++) exp_q[k].push_back(8'h07);
      @(negedge CLK);
      tdin1 = 8'h07;
      wrn1  = 1'b1;
      @(negedge CLK);
      wrn1  = 1'b0;
      @(posedge CLK);
      #1;
      check_eq("t5 start p1", 32'(txd_w[1]), 32'd0);
      for (int k = 0; k < 4; k++) len[k] = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(posedge CLK);
         #1;
         if (i == 600) begin
            check_eq("t5 even parity bit", 32'(txd_w[1]), 32'd1);
            check_eq("t5 odd parity bit", 32'(txd_w[2]), 32'd0);
         end
         for (int k = 1; k < 4; k++)
            if (tsre_w[k] && len[k] == 0) len[k] = i;
      end
      check_eq("t5 len even", 32'(len[1]), 32'd704);
      check_eq("t5 len odd", 32'(len[2]), 32'd704);
      check_eq("t5 len 2stop", 32'(len[3]), 32'd704);

      // 6a: wrn held high sends exactly one frame
      st_q.delete();
      exp_q[0].push_back(8'h5A);
      @(negedge CLK);
      tdin0 = 8'h5A;
      wrn0  = 1'b1;
      repeat (2000) @(negedge CLK);
      wrn0 = 1'b0;
      check_eq("t6 frames while held", 32'(st_q.size()), 32'd1);
      check_eq("t6 tsre after hold", 32'(tsre_w[0]), 32'd1);

      // 6b: reset mid-frame with a byte queued
      @(negedge CLK);
      tdin0 = 8'hC3;
      wrn0  = 1'b1;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      wrn0 = 1'b0;
      repeat (20) @(negedge CLK);
      write0(8'h99);
      check_eq("t6 tbuf queued", 32'(tbuf_w[0]), 32'd1);
      repeat (258) @(negedge CLK);
      check_eq("t6 data bit3", 32'(txd_w[0]), 32'd0);
      BTND = 1'b1;
      @(posedge CLK);
      #1;
      check_eq("t6 txd after reset", 32'(txd_w[0]), 32'd1);
      check_eq("t6 tbuf after reset", 32'(tbuf_w[0]), 32'd0);
      check_eq("t6 tsre after reset", 32'(tsre_w[0]), 32'd1);
      @(negedge CLK);
      BTND = 1'b0;
      viol = 0;
      repeat (1500) begin
         @(negedge CLK);
         if (txd_w[0] !== 1'b1) viol++;
      end
      check_eq("t6 line quiet after reset", 32'(viol), 32'd0);

      for (int k = 0; k < 4; k++)
         check_eq($sformatf("d%0d leftover expected", k), 32'(exp_q[k].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
